// File: rtl/bulls_cows_pkg.sv
// Shared definitions for the Bulls-and-Cows round controller.
//   state_e     : round sequencing states
//   NUM_DIGITS  : digits in a secret / guess
//   DIGIT_W     : bits per BCD digit
//   WIN_STRIKES : strike count that ends the round as a win
package bulls_cows_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int DIGIT_W     = 4;
  localparam int WIN_STRIKES = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ENTRY  = 3'd2,
    SCORE  = 3'd3,
    REPORT = 3'd4,
    WIN    = 3'd5,
    LOSE   = 3'd6
  } state_e;

endpackage

// File: rtl/guess_entry_buf.sv
// Four-slot guess buffer with entry counter.
// Slot 0 lives in guess_o[15:12], slot 3 in guess_o[3:0].
// Optional feature macro: DUP_CHECK_EN -- when defined, a digit equal to an
// already-entered slot is refused, so the scorer only sees distinct digits.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : zero the buffer and counter (wins over wr_i)
//   wr_i       : store digit_i if accept_o is high
//   digit_i    : candidate digit
//   guess_o    : buffer contents
//   cnt_o      : digits stored, 0..4
//   accept_o   : digit_i would be stored (in range, buffer not full, no dup)
module guess_entry_buf
  import bulls_cows_pkg::*;
#(
  parameter int DIGIT_MAX = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_i,
  input  logic                          wr_i,
  input  logic [DIGIT_W-1:0]            digit_i,
  output logic [NUM_DIGITS*DIGIT_W-1:0] guess_o,
  output logic [2:0]                    cnt_o,
  output logic                          accept_o
);

  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);

  logic [NUM_DIGITS*DIGIT_W-1:0] guess_q, guess_d;
  logic [2:0]                    cnt_q, cnt_d;
  logic                          full, too_big, dup;

  always_comb begin
    full    = (cnt_q == 3'(NUM_DIGITS));
    too_big = (digit_i > DMAX);
    dup     = 1'b0;
`ifdef DUP_CHECK_EN
    // Only slots below the counter hold live digits.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((3'(i) < cnt_q) &&
          (guess_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] == digit_i)) begin
        dup = 1'b1;
      end
    end
`endif
    accept_o = !full && !too_big && !dup;

    guess_d = guess_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      guess_d = '0;
      cnt_d   = '0;
    end else if (wr_i && accept_o) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cnt_q == 3'(i)) begin
          guess_d[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digit_i;
        end
      end
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      guess_q <= '0;
      cnt_q   <= '0;
    end else begin
      guess_q <= guess_d;
      cnt_q   <= cnt_d;
    end
  end

  assign guess_o = guess_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/bulls_cows_game_ctrl.sv
// Sequencing controller for one Bulls-and-Cows round: latches the secret,
// collects four keypad digits, hands secret/guess to the external
// combinational scorer, registers its STRIKE/BALL and counts attempts.
// Optional feature macro: DUP_CHECK_EN (duplicate-digit rejection, applied
// inside guess_entry_buf).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   new_game            : pulse, abandon any round and reload a secret
//   secret_valid/secret : secret source, latched in LOAD
//   key_valid/key_digit : keypad digit pulse
//   key_clear/key_enter : discard partial guess / submit guess
//   secret_out/guess_out: operands for the scorer
//   strike_in/ball_in   : scorer result, sampled in SCORE
//   strike/ball         : registered result of the last scored guess
//   result_valid        : high for the single REPORT cycle
//   tries               : guesses scored this round
//   entry_cnt           : digits in the guess buffer
//   busy                : high in LOAD and SCORE
//   key_err             : high the cycle after a rejected key
//   win/lose            : round outcome levels
//   dbg_state           : current FSM state for observation
//
// Input handshake: all keypad and control inputs are single-cycle pulses
// with no ready; a pulse is either consumed on the edge that samples it or
// dropped. Same-cycle priority is rst > new_game > key_clear > key_valid >
// key_enter, and a dropped lower-priority pulse never raises key_err.
module bulls_cows_game_ctrl
  import bulls_cows_pkg::*;
#(
  parameter int MAX_TRIES = 10,
  parameter int DIGIT_MAX = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        secret_valid,
  input  logic [15:0] secret,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clear,
  input  logic        key_enter,
  output logic [15:0] secret_out,
  output logic [15:0] guess_out,
  input  logic [2:0]  strike_in,
  input  logic [2:0]  ball_in,
  output logic [2:0]  strike,
  output logic [2:0]  ball,
  output logic        result_valid,
  output logic [3:0]  tries,
  output logic [2:0]  entry_cnt,
  output logic        busy,
  output logic        key_err,
  output logic        win,
  output logic        lose,
  output state_e      dbg_state
);

  localparam logic [3:0] TMAX = 4'(MAX_TRIES);

  state_e      state_q, state_d;
  logic [15:0] secret_q, secret_d;
  logic [2:0]  strike_q, strike_d;
  logic [2:0]  ball_q, ball_d;
  logic [3:0]  tries_q, tries_d;
  logic        key_err_q, key_err_d;
  logic        buf_clear, buf_wr, buf_accept;

  guess_entry_buf #(
    .DIGIT_MAX (DIGIT_MAX)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (buf_clear),
    .wr_i     (buf_wr),
    .digit_i  (key_digit),
    .guess_o  (guess_out),
    .cnt_o    (entry_cnt),
    .accept_o (buf_accept)
  );

  always_comb begin
    state_d   = state_q;
    secret_d  = secret_q;
    strike_d  = strike_q;
    ball_d    = ball_q;
    tries_d   = tries_q;
    key_err_d = 1'b0;
    buf_clear = 1'b0;
    buf_wr    = 1'b0;

    if (new_game) begin
      // secret_q is deliberately kept until the next secret is latched.
      state_d   = LOAD;
      strike_d  = '0;
      ball_d    = '0;
      tries_d   = '0;
      buf_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        LOAD: begin
          if (secret_valid) begin
            secret_d = secret;
            state_d  = ENTRY;
          end
        end
        ENTRY: begin
          if (key_clear) begin
            buf_clear = 1'b1;
          end else if (key_valid) begin
            buf_wr    = 1'b1;
            key_err_d = !buf_accept;
          end else if (key_enter) begin
            if (entry_cnt == 3'(NUM_DIGITS)) state_d = SCORE;
            else                              key_err_d = 1'b1;
          end
        end
        SCORE: begin
          // Operands have been stable since the enter edge, so the
          // combinational scorer has settled by now.
          strike_d = strike_in;
          ball_d   = ball_in;
          if (tries_q < TMAX) tries_d = tries_q + 4'd1;
          state_d  = REPORT;
        end
        REPORT: begin
          if (strike_q == 3'(WIN_STRIKES)) begin
            state_d = WIN;
          end else if (tries_q == TMAX) begin
            state_d = LOSE;
          end else begin
            buf_clear = 1'b1;
            state_d   = ENTRY;
          end
        end
        WIN, LOSE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      secret_q  <= '0;
      strike_q  <= '0;
      ball_q    <= '0;
      tries_q   <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      secret_q  <= secret_d;
      strike_q  <= strike_d;
      ball_q    <= ball_d;
      tries_q   <= tries_d;
      key_err_q <= key_err_d;
    end
  end

  assign secret_out   = secret_q;
  assign strike       = strike_q;
  assign ball         = ball_q;
  assign tries        = tries_q;
  assign key_err      = key_err_q;
  assign result_valid = (state_q == REPORT);
  assign busy         = (state_q == LOAD) || (state_q == SCORE);
  assign win          = (state_q == WIN);
  assign lose         = (state_q == LOSE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_bulls_cows_game_ctrl.sv
// Bench for bulls_cows_game_ctrl: directed round scenarios followed by
// randomized pulses on every input, all checked each cycle against a
// behavioural model of the round rules.
module tb_bulls_cows_game_ctrl;
  import bulls_cows_pkg::*;

  localparam int MT   = 2;
  localparam int DMAX = 9;
`ifdef DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        new_game = 1'b0;
  logic        secret_valid = 1'b0;
  logic [15:0] secret = '0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = '0;
  logic        key_clear = 1'b0;
  logic        key_enter = 1'b0;
  logic [15:0] secret_out, guess_out;
  logic [2:0]  strike_in, ball_in, strike, ball, entry_cnt;
  logic        result_valid, busy, key_err, win, lose;
  logic [3:0]  tries;
  state_e      dbg_state;

  always #5 clk = ~clk;

  bulls_cows_game_ctrl #(.MAX_TRIES(MT), .DIGIT_MAX(DMAX)) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .secret_valid(secret_valid), .secret(secret),
    .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .key_enter(key_enter),
    .secret_out(secret_out), .guess_out(guess_out),
    .strike_in(strike_in), .ball_in(ball_in),
    .strike(strike), .ball(ball), .result_valid(result_valid),
    .tries(tries), .entry_cnt(entry_cnt), .busy(busy),
    .key_err(key_err), .win(win), .lose(lose), .dbg_state(dbg_state)
  );

  // Bulls-and-Cows scoring: same digit same place is a strike, same digit
  // other place is a ball. Used as the external scorer and by the model.
  function automatic logic [5:0] score(input logic [15:0] s, input logic [15:0] g);
    int st, bl;
    st = 0;
    bl = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (g[4*(3-i) +: 4] == s[4*(3-j) +: 4]) begin
          if (i == j) st++;
          else        bl++;
        end
    return {3'(st), 3'(bl)};
  endfunction

  always_comb {strike_in, ball_in} = score(secret_out, guess_out);

  // ---------------- scoreboard / checker ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  state_e      m_state = IDLE;
  logic [15:0] m_secret = '0;
  int          m_g[4] = '{default: 0};
  int          m_cnt = 0, m_tries = 0, m_st = 0, m_bl = 0;
  bit          m_kerr = 1'b0;

  function automatic logic [15:0] pack_guess();
    logic [15:0] p;
    for (int i = 0; i < 4; i++) p[4*(3-i) +: 4] = 4'(m_g[i]);
    return p;
  endfunction

  task automatic model_step();
    bit bad;
    logic [5:0] r;
    m_kerr = 1'b0;
    if (rst) begin
      m_state = IDLE; m_secret = '0; m_g = '{default: 0};
      m_cnt = 0; m_tries = 0; m_st = 0; m_bl = 0;
    end else if (new_game) begin
      m_state = LOAD; m_g = '{default: 0};
      m_cnt = 0; m_tries = 0; m_st = 0; m_bl = 0;
    end else begin
      case (m_state)
        LOAD: if (secret_valid) begin m_secret = secret; m_state = ENTRY; end
        ENTRY: begin
          if (key_clear) begin
            m_g = '{default: 0}; m_cnt = 0;
          end else if (key_valid) begin
            bad = (int'(key_digit) > DMAX) || (m_cnt == 4);
            if (DUP) for (int i = 0; i < m_cnt; i++) if (m_g[i] == int'(key_digit)) bad = 1'b1;
            if (bad) m_kerr = 1'b1;
            else begin m_g[m_cnt] = int'(key_digit); m_cnt++; end
          end else if (key_enter) begin
            if (m_cnt == 4) m_state = SCORE;
            else            m_kerr = 1'b1;
          end
        end
        SCORE: begin
          r = score(m_secret, pack_guess());
          m_st = int'(r[5:3]); m_bl = int'(r[2:0]);
          m_tries++;
          exp_q.push_back(r);
          m_state = REPORT;
        end
        REPORT: begin
          if (m_st == 4)            m_state = WIN;
          else if (m_tries == MT)   m_state = LOSE;
          else begin m_g = '{default: 0}; m_cnt = 0; m_state = ENTRY; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [5:0] e;
    check_eq("secret_out", secret_out, m_secret);
    check_eq("guess_out", guess_out, pack_guess());
    check_eq("strike", strike, m_st);
    check_eq("ball", ball, m_bl);
    check_eq("tries", tries, m_tries);
    check_eq("entry_cnt", entry_cnt, m_cnt);
    check_eq("busy", busy, (m_state == LOAD) || (m_state == SCORE));
    check_eq("key_err", key_err, m_kerr);
    check_eq("result_valid", result_valid, m_state == REPORT);
    check_eq("win", win, m_state == WIN);
    check_eq("lose", lose, m_state == LOSE);
    check_eq("state", dbg_state, m_state);
    if (result_valid) begin
      check_eq("sb_has_entry", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sb_result", {strike, ball}, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit ng, input bit sv, input logic [15:0] s,
                       input bit kv, input logic [3:0] kd, input bit kc, input bit ke);
    new_game = ng; secret_valid = sv; secret = s;
    key_valid = kv; key_digit = kd; key_clear = kc; key_enter = ke;
    tick();
    new_game = 0; secret_valid = 0; key_valid = 0; key_clear = 0; key_enter = 0;
  endtask

  task automatic idle_cyc();                 drive(0, 0, '0, 0, '0, 0, 0); endtask
  task automatic press(input logic [3:0] d); drive(0, 0, '0, 1, d, 0, 0);  endtask
  task automatic enter_key();                drive(0, 0, '0, 0, '0, 0, 1); endtask
  task automatic clear_key();                drive(0, 0, '0, 0, '0, 1, 0); endtask

  task automatic start_round(input logic [15:0] s);
    drive(1, 0, '0, 0, '0, 0, 0);
    drive(0, 1, s, 0, '0, 0, 0);
  endtask

  task automatic type_guess(input logic [15:0] g);
    for (int i = 0; i < 4; i++) press(g[4*(3-i) +: 4]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_secret();
    int d[10];
    int j, t;
    for (int i = 0; i < 10; i++) d[i] = i;
    for (int i = 9; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = d[i]; d[i] = d[j]; d[j] = t;
    end
    return {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check_eq("rst_secret_out", secret_out, 16'h0);
    check_eq("rst_state", dbg_state, IDLE);

    // Exact guess wins on the first try.
    start_round(16'h1234);
    type_guess(16'h1234);
    enter_key();
    check_eq("t1_busy_in_score", busy, 1);
    idle_cyc();
    check_eq("t1_strike", strike, 4);
    check_eq("t1_ball", ball, 0);
    check_eq("t1_tries", tries, 1);
    check_eq("t1_result_valid", result_valid, 1);
    idle_cyc();
    check_eq("t1_win", win, 1);
    check_eq("t1_rv_dropped", result_valid, 0);

    // All digits misplaced: four balls, back to entry.
    start_round(16'h1234);
    type_guess(16'h4321);
    enter_key();
    idle_cyc();
    check_eq("t2_strike", strike, 0);
    check_eq("t2_ball", ball, 4);
    idle_cyc();
    check_eq("t2_entry_cnt", entry_cnt, 0);
    check_eq("t2_state", dbg_state, ENTRY);

    // Out of tries.
    start_round(16'h1234);
    for (int k = 0; k < 2; k++) begin
      type_guess(16'h5678);
      enter_key();
      idle_cyc();
      idle_cyc();
    end
    check_eq("t3_lose", lose, 1);
    check_eq("t3_tries", tries, 2);
    press(4'd3);
    check_eq("t3_key_ignored_err", key_err, 0);
    check_eq("t3_key_ignored_cnt", entry_cnt, 4);

    // Short enter, out-of-range digit, clear, full buffer.
    start_round(16'h1234);
    press(4'd1);
    press(4'd2);
    enter_key();
    check_eq("t4_short_enter_err", key_err, 1);
    check_eq("t4_no_score", dbg_state, ENTRY);
    press(4'hA);
    check_eq("t4_big_digit_err", key_err, 1);
    check_eq("t4_big_digit_cnt", entry_cnt, 2);
    clear_key();
    check_eq("t4_clear_cnt", entry_cnt, 0);
    check_eq("t4_clear_guess", guess_out, 16'h0);
    press(4'd1);
    press(4'd1);
    check_eq("t5_dup_cnt", entry_cnt, DUP ? 1 : 2);
    check_eq("t5_dup_err", key_err, DUP ? 1 : 0);
    clear_key();
    type_guess(16'h5678);
    press(4'd9);
    check_eq("t5_full_err", key_err, 1);
    check_eq("t5_full_cnt", entry_cnt, 4);

    // new_game during SCORE wins over a same-cycle key.
    start_round(16'h1234);
    type_guess(16'h5678);
    enter_key();
    idle_cyc();
    idle_cyc();
    type_guess(16'h5679);
    enter_key();
    drive(1, 0, '0, 1, 4'd3, 0, 0);
    check_eq("t6_load", dbg_state, LOAD);
    check_eq("t6_tries", tries, 0);
    check_eq("t6_cnt", entry_cnt, 0);
    check_eq("t6_old_secret", secret_out, 16'h1234);
    check_eq("t6_no_err", key_err, 0);

    // rst mid-entry wins over a same-cycle key.
    drive(0, 1, 16'h9876, 0, '0, 0, 0);
    press(4'd1);
    press(4'd2);
    rst = 1'b1;
    drive(0, 0, '0, 1, 4'd3, 0, 0);
    rst = 1'b0;
    check_eq("t6_rst_state", dbg_state, IDLE);
    check_eq("t6_rst_secret", secret_out, 16'h0);
    check_eq("t6_rst_cnt", entry_cnt, 0);
    check_eq("t6_rst_guess", guess_out, 16'h0);

    // Randomized pulses on every input, tracked by the model.
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] d;
      if ($urandom_range(0, 9) < 6) d = m_secret[4*(3-(m_cnt % 4)) +: 4];
      else                          d = 4'($urandom_range(0, 11));
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, rand_secret(),
            $urandom_range(0, 1) == 1, d, $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) == 0);
      rst = 1'b0;
    end

    idle_cyc();
    idle_cyc();
    check_eq("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bulls_cows_game_ctrl.md
# bulls_cows_game_ctrl

Sequencing controller for one Bulls-and-Cows round. It latches a 4-digit secret from the random-number source and collects four player digits from the keypad. It presents secret and guess to the combinational `cnt_strike_ball` scorer, registers the STRIKE/BALL result and counts attempts. It sits between the keypad/random-number front end and the display driver, and owns all game state.

## Interface
Parameters:
- MAX_TRIES, 10: attempts allowed before LOSE; legal range 1..15.
- DIGIT_MAX, 9: largest legal decimal digit; keypad codes above it are ignored.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- new_game  in  1  single-cycle pulse; starts a round from any state.
- secret_valid  in  1  secret bus is valid this cycle.
- secret  in  16  four BCD digits, [15:12] is the first digit.
- key_valid  in  1  single-cycle pulse; key_digit is valid.
- key_digit  in  4  entered digit.
- key_clear  in  1  discard the partially entered guess.
- key_enter  in  1  submit the guess.
- secret_out  out  16  latched secret, driven to the scorer random_num.
- guess_out  out  16  guess buffer, driven to scorer Reg_1..Reg_4 as [15:12]..[3:0].
- strike_in  in  3  scorer STRIKE.
- ball_in  in  3  scorer BALL.
- strike  out  3  registered strikes of the last scored guess.
- ball  out  3  registered balls of the last scored guess.
- result_valid  out  1  one-cycle pulse when strike/ball update.
- tries  out  4  guesses scored this round.
- entry_cnt  out  3  digits currently in the buffer, 0..4.
- busy  out  1  high in LOAD and SCORE.
- key_err  out  1  one-cycle pulse when a key is rejected.
- win  out  1  level; high in WIN.
- lose  out  1  level; high in LOSE.

## Operation
- State IDLE: waits for new_game, then goes to LOAD and clears tries, entry_cnt, strike, ball and guess_out.
- State LOAD: waits for secret_valid. On secret_valid, latches secret into secret_out and goes to ENTRY.
- State ENTRY, handling a key_valid pulse:
  - A digit greater than DIGIT_MAX is rejected and pulses key_err.
  - When entry_cnt==4, any digit is rejected and pulses key_err.
  - Otherwise the digit is written into slot entry_cnt (slot 0 is [15:12]) and entry_cnt increments.
- State ENTRY, other inputs:
  - key_clear zeroes guess_out and entry_cnt.
  - key_enter with entry_cnt==4 goes to SCORE.
  - key_enter with entry_cnt<4 is ignored and pulses key_err.
- Input priority within one cycle: rst > new_game > key_clear > key_valid > key_enter. Any lower-priority event that loses is dropped with no key_err.
- State SCORE (exactly one cycle):
  - Captures strike_in/ball_in into strike/ball and increments tries.
  - Goes to REPORT.
- State REPORT (exactly one cycle):
  - result_valid=1.
  - If strike==4, goes to WIN.
  - Else if tries==MAX_TRIES, goes to LOSE.
  - Else clears guess_out and entry_cnt and returns to ENTRY.
- States WIN and LOSE:
  - Hold all outputs, including the final strike/ball.
  - Keys are ignored with no key_err.
  - new_game goes to LOAD.
- new_game in any state, including mid-entry and SCORE:
  - Abandons the round and goes to LOAD.
  - secret_out keeps its old value until the new secret is latched.

## Timing
- Reset values: state IDLE; every output 0, including secret_out, guess_out, strike, ball, tries, entry_cnt, busy, key_err, result_valid, win and lose.
- Key acceptance: entry_cnt and guess_out update on the clock edge that samples key_valid.
- Score latency: key_enter accepted in cycle N → SCORE at N+1 → strike/ball/tries updated at the N+2 edge with result_valid high during N+2. Win/lose is asserted from N+3.
- Scorer input stability: guess_out and secret_out are stable from cycle N through SCORE, so the combinational scorer settles within one cycle.
- tries never exceeds MAX_TRIES and never wraps.
- key_err is high only for the cycle following the rejected key.

## Configuration
- DUP_CHECK_EN defined: in ENTRY, a key_valid digit equal to any already-entered slot (indices < entry_cnt) is rejected with key_err and is not stored. This guarantees the scorer only sees distinct-digit guesses.
- DUP_CHECK_EN undefined: duplicate digits are accepted like any other legal digit.

## Structure
- Shared package `bulls_cows_pkg` holds:
  - the state enum (IDLE, LOAD, ENTRY, SCORE, REPORT, WIN, LOSE);
  - the constants NUM_DIGITS=4, DIGIT_W=4 and WIN_STRIKES=4.
- One natural sub-module, `guess_entry_buf`: owns the 4-slot buffer, entry_cnt, the clear/write logic and the DUP_CHECK_EN compare. It reports accept/reject back to the FSM.
- The scorer is instantiated next to this block at the top level, not inside it.

## Test plan
- Reset then new_game, secret_valid with secret=16'h1234; keys 1,2,3,4 then enter → after 2 cycles strike=4, ball=0, tries=1, result_valid one pulse, win=1 the following cycle.
- Secret 16'h1234, guess 4,3,2,1 then enter → strike=0, ball=4, tries=1, return to ENTRY with entry_cnt=0.
- MAX_TRIES=2, secret 16'h1234, guesses 5678 twice → after the second REPORT lose=1, tries=2; a further key_valid has no effect and no key_err.
- Keys 1,2 then enter → key_err pulse, no SCORE; key_digit=4'hA → key_err; key_clear → entry_cnt=0, guess_out=0.
- With DUP_CHECK_EN defined, keys 1,1 → second key rejects with key_err and entry_cnt=1. With DUP_CHECK_EN undefined → entry_cnt=2.
- new_game asserted during SCORE, and separately rst asserted mid-entry → LOAD with tries=0 (new_game), respectively IDLE with all outputs 0 (rst); the same-cycle key_valid is dropped.
